// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save stream accumulator: state encoding and sizing helpers.
// No logic; imported by csa_stream_accumulator.
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        OUT     = 2'd2
    } csa_state_t;

    function automatic int n_chunks(input int acc_w, input int chunk);
        return acc_w / chunk;
    endfunction

    // Chunk-index width; a lone chunk still needs one bit of index.
    function automatic int chunk_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/csa_compress_3to2.sv
// Bitwise 3:2 compressor: sum = a^b^c, carry = majority(a,b,c), carry left unshifted.
// Latency: combinational. Backpressure: none.
module csa_compress_3to2 #(
    parameter int WIDTH = 32
)(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_stream_accumulator.sv
// Multi-operand summation: 3:2 carry-save accumulation, then an N_CHUNKS-cycle chunked ripple resolve.
// Latency: out_valid rises N_CHUNKS edges after the in_last beat is accepted; CSA_ACC_SIGNED_EN selects sign extension.
// Backpressure: in_ready only while accumulating; the result is held until out_ready.
module csa_stream_accumulator
    import csa_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int GUARD     = 8,
    parameter int CPA_CHUNK = 8
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH+GUARD-1:0]   out_sum,
    output logic                     out_ovf
);

    localparam int ACC_W    = WIDTH + GUARD;
    localparam int N_CHUNKS = n_chunks(ACC_W, CPA_CHUNK);
    localparam int K_W      = chunk_idx_w(N_CHUNKS);
    localparam int CNT_W    = GUARD + 2;

    localparam logic [K_W-1:0]   K_LAST  = K_W'(N_CHUNKS - 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(1 << GUARD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << GUARD) + 1);

    csa_state_t        state;
    logic [ACC_W-1:0]  s_q;
    logic [ACC_W-1:0]  c_q;
    logic [CNT_W-1:0]  cnt;
    logic [K_W-1:0]    k;
    logic              cy;

    logic [ACC_W-1:0]  x;
    logic [ACC_W-1:0]  s_next;
    logic [ACC_W-1:0]  c_next;
    logic [ACC_W-2:0]  sum_lo;
    logic [ACC_W-2:0]  maj_lo;

`ifdef CSA_ACC_SIGNED_EN
    assign x = {{GUARD{in_data[WIDTH-1]}}, in_data};
`else
    assign x = {{GUARD{1'b0}}, in_data};
`endif

    // The top bit's majority would only feed the discarded carry-out, so compress the low bits only.
    csa_compress_3to2 #(.WIDTH(ACC_W - 1)) u_compress (
        .a     (s_q[ACC_W-2:0]),
        .b     (c_q[ACC_W-2:0]),
        .c     (x[ACC_W-2:0]),
        .sum   (sum_lo),
        .carry (maj_lo)
    );

    assign s_next = {s_q[ACC_W-1] ^ c_q[ACC_W-1] ^ x[ACC_W-1], sum_lo};
    assign c_next = {maj_lo, 1'b0};

    logic [CPA_CHUNK-1:0] s_chunk;
    logic [CPA_CHUNK-1:0] c_chunk;
    logic [CPA_CHUNK:0]   chunk_sum;

    assign s_chunk   = s_q[k*CPA_CHUNK +: CPA_CHUNK];
    assign c_chunk   = c_q[k*CPA_CHUNK +: CPA_CHUNK];
    assign chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CPA_CHUNK{1'b0}}, cy};

    assign in_ready = (state == ACCUM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            s_q       <= '0;
            c_q       <= '0;
            cnt       <= '0;
            k         <= '0;
            cy        <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        s_q <= s_next;
                        c_q <= c_next;
                        if (cnt != CNT_MAX)
                            cnt <= cnt + 1'b1;
                        if (in_last) begin
                            state <= RESOLVE;
                            k     <= '0;
                            cy    <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    out_sum[k*CPA_CHUNK +: CPA_CHUNK] <= chunk_sum[CPA_CHUNK-1:0];
                    cy <= chunk_sum[CPA_CHUNK];
                    k  <= k + 1'b1;
                    if (k == K_LAST) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_ovf   <= (cnt > CNT_LIM);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        s_q       <= '0;
                        c_q       <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Self-checking bench for csa_stream_accumulator at WIDTH=8, GUARD=4, CPA_CHUNK=4 (ACC_W=12, 3 chunks).
module tb_csa_stream_accumulator;

    localparam int WIDTH = 8;
    localparam int GUARD = 4;
    localparam int CHUNK = 4;
    localparam int ACC_W = WIDTH + GUARD;
    localparam int NCH   = ACC_W / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] ops_q[$];

    csa_stream_accumulator #(.WIDTH(WIDTH), .GUARD(GUARD), .CPA_CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        int               n;
        logic [WIDTH-1:0] first;
        logic [WIDTH-1:0] inc;
        int               gap;
        logic [ACC_W-1:0] exp_sum;
        logic             exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Streams ops_q, waits for the result, holds it for 'hold' cycles, then handshakes.
    task automatic run_packet(input string name, input int gap, input int hold,
                              input logic [ACC_W-1:0] exp_sum, input logic exp_ovf);
        int lat;
        for (int i = 0; i < ops_q.size(); i++) begin
            check({name, "_in_ready_beat"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = ops_q[i];
            in_last  = (i == ops_q.size() - 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (i != ops_q.size() - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
            end
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'(NCH));
        check({name, "_sum"}, 32'(out_sum), 32'(exp_sum));
        check({name, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            in_last  = 1'b1;
            @(posedge clk); #1;
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_sum"}, 32'(out_sum), 32'(exp_sum));
            check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_post_valid"}, 32'(out_valid), 32'd0);
        check({name, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"single_a5", 1,  8'hA5, 8'h00, 0, 12'h0A5, 1'b0};
        vecs[1] = '{"ff_x16",    16, 8'hFF, 8'h00, 0, 12'hFF0, 1'b0};
`ifdef CSA_ACC_SIGNED_EN
        vecs[2] = '{"ff_x17",    17, 8'hFF, 8'h00, 0, 12'hFEF, 1'b1};
        vecs[4] = '{"ff_then_1", 2,  8'hFF, 8'h02, 0, 12'h000, 1'b0};
`else
        vecs[2] = '{"ff_x17",    17, 8'hFF, 8'h00, 0, 12'h0EF, 1'b1};
        vecs[4] = '{"ff_then_1", 2,  8'hFF, 8'h02, 0, 12'h100, 1'b0};
`endif
        vecs[3] = '{"gap_123",   3,  8'h01, 8'h01, 2, 12'h006, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_sum", 32'(out_sum), 32'd0);
        check("reset_out_ovf", 32'(out_ovf), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            ops_q.delete();
            for (int i = 0; i < vecs[v].n; i++)
                ops_q.push_back(WIDTH'(vecs[v].first + WIDTH'(i) * vecs[v].inc));
            run_packet(vecs[v].name, vecs[v].gap, 0, vecs[v].exp_sum, vecs[v].exp_ovf);
        end

        // Result held under backpressure while in_valid pulses are ignored.
        ops_q.delete();
        ops_q.push_back(8'h10);
        ops_q.push_back(8'h20);
        run_packet("hold5", 0, 5, 12'h030, 1'b0);

        // Reset during the second resolve cycle abandons the packet.
        in_valid = 1'b1; in_data = 8'h09; in_last = 1'b0;
        @(posedge clk); #1;
        in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_result", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
        ops_q.delete();
        ops_q.push_back(8'h03);
        ops_q.push_back(8'h04);
        run_packet("after_rst", 0, 0, 12'h007, 1'b0);

        // Randomized packets against an arithmetic reference.
        for (int p = 0; p < 25; p++) begin
            int acc;
            int n;
            logic [ACC_W-1:0] es;
            n   = $urandom_range(1, 20);
            acc = 0;
            ops_q.delete();
            for (int i = 0; i < n; i++) begin
                logic [WIDTH-1:0] op;
                op = WIDTH'($urandom);
                ops_q.push_back(op);
`ifdef CSA_ACC_SIGNED_EN
                acc += int'($signed(op));
`else
                acc += int'(op);
`endif
            end
            es = acc[ACC_W-1:0];
            run_packet($sformatf("rand%0d", p), $urandom_range(0, 1), $urandom_range(0, 2),
                       es, n > (1 << GUARD));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
